// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// saturation to MAX_VAL and a leading-zero blank mask for the 7-segment scanner.
module bin2bcd_seq #(
  parameter int IN_W     = 14,
  parameter int DIGITS   = 4,
  parameter int MAX_VAL  = 9999,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int                BCD_W     = 4 * DIGITS;
  localparam int                CNT_W     = $clog2(IN_W);
  localparam logic [IN_W-1:0]   MAX_BIN   = IN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(IN_W - 1);
  // Idle display shows a single "0": every digit except the units is blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = BLANK_LZ ? {{(DIGITS-1){1'b1}}, 1'b0} : '0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  sreg;
  logic [BCD_W-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             ovf_next;

  logic [BCD_W-1:0]  work_adj;
  logic [DIGITS-1:0] blank_mask;
  logic              zero_above;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    work_adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) begin
        work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
      end
    end
  end

  // Digit i is blanked only when it and every more significant digit are zero.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (work[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_above;
    end
    if (!BLANK_LZ) begin
      blank_mask = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg     <= (bin > MAX_BIN) ? MAX_BIN : bin;
            ovf_next <= (bin > MAX_BIN);
            work     <= '0;
            cnt      <= CNT_LAST;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {work, sreg} <= {work_adj, sreg} << 1;
          cnt          <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= work;
          blank <= blank_mask;
          ovf   <= ovf_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
